// File: rtl/seq_arb_pkg.sv
// Shared types and helpers for the sequential-resource round-robin arbiter.
package seq_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  // The rotating search views the request vector doubled, so wrap-around is a plain shift.
  function automatic int rr_search_w(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/seq_rr_arbiter_rr_pick.sv
// Rotating-priority picker: first set request at or above ptr, wrapping to 0.
module rr_pick
  import seq_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  sel,
  output logic             found
);

  localparam int SW = rr_search_w(N_REQ);

  logic [SW-1:0]    dbl;
  logic [N_REQ-1:0] rot;

  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[N_REQ-1:0];
    sel   = '0;
    found = 1'b0;
    // Scan downward so the lowest rotated offset (closest to ptr) wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        sel   = ID_W'((int'(ptr) + i) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/seq_rr_arbiter.sv
// Round-robin owner arbiter for one shared sequential datapath: registered grant,
// bounded hold with forced revoke, and one dead cycle between owners.
module seq_rr_arbiter
  import seq_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 16,
  localparam int ID_W    = $clog2(N_REQ),
  localparam int HOLD_W  = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             rel,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             busy,
  output logic             timeout
);

  arb_state_e        state, state_nx;
  logic [ID_W-1:0]   ptr, ptr_nx, sel, id_nx;
  logic [HOLD_W-1:0] hold_cnt, hold_nx;
  logic [N_REQ-1:0]  gnt_nx;
  logic              busy_nx, timeout_nx, found;
  logic              withdraw, limit_hit, release_now;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .sel   (sel),
    .found (found)
  );

  assign withdraw    = !req[gnt_id];
  assign limit_hit   = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign release_now = rel || withdraw || limit_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      hold_cnt <= hold_nx;
      gnt      <= gnt_nx;
      gnt_id   <= id_nx;
      busy     <= busy_nx;
      timeout  <= timeout_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, GAP: state_nx = found ? BUSY : IDLE;
      BUSY:      state_nx = release_now ? GAP : BUSY;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    ptr_nx     = ptr;
    hold_nx    = hold_cnt;
    gnt_nx     = gnt;
    id_nx      = gnt_id;
    busy_nx    = busy;
    timeout_nx = 1'b0;
    case (state)
      IDLE, GAP: begin
        gnt_nx  = found ? (N_REQ'(1) << sel) : '0;
        id_nx   = found ? sel : '0;
        busy_nx = found;
        hold_nx = '0;
      end
      BUSY: begin
        if (release_now) begin
          gnt_nx     = '0;
          id_nx      = '0;
          busy_nx    = 1'b0;
          ptr_nx     = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
          // A voluntary release or withdrawal outranks the hold limit.
          timeout_nx = !rel && !withdraw;
        end else if (hold_cnt != '1) begin
          hold_nx = hold_cnt + 1'b1;
        end
      end
      default: begin
        gnt_nx  = '0;
        id_nx   = '0;
        busy_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_rr_arbiter.sv
// Directed scoreboard bench for seq_rr_arbiter with N_REQ=4, MAX_HOLD=16.
module tb_seq_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rel = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy, timeout;

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seq_rr_arbiter #(.N_REQ(4), .MAX_HOLD(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .rel     (rel),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  function automatic logic [3:0] oh(input int k);
    return 4'(1 << k);
  endfunction

  task automatic check_head();
    exp_t e;
    e = sb.pop_front();
    total++;
    assert ({gnt, gnt_id, busy, timeout} === {e.gnt, e.id, e.busy, e.to})
    else begin
      bad++;
      $error("FAIL %s gnt/id/busy/timeout got %b/%0d/%b/%b want %b/%0d/%b/%b",
             e.tag, gnt, gnt_id, busy, timeout, e.gnt, e.id, e.busy, e.to);
    end
  endtask

  // Expect the given outputs after the next rising edge.
  task automatic cyc(input string tag, input logic [3:0] g, input logic [1:0] id,
                     input logic b, input logic t);
    sb.push_back('{tag, g, id, b, t});
    @(posedge clk);
    #1;
    check_head();
  endtask

  // Expect the given outputs right now, with no clock edge involved.
  task automatic now_chk(input string tag, input logic [3:0] g, input logic [1:0] id,
                         input logic b, input logic t);
    sb.push_back('{tag, g, id, b, t});
    check_head();
  endtask

  initial begin
    // Reset held with every requester active.
    req = 4'b1111;
    #12;
    now_chk("rst_hold", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc("rst_release", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Rotation 0,1,2,3,0 with a 3-cycle hold and one dead cycle between owners.
    for (int k = 0; k < 4; k++) begin
      rel = 1'b0;
      cyc("rot_hold", oh(k), 2'(k), 1'b1, 1'b0);
      cyc("rot_hold", oh(k), 2'(k), 1'b1, 1'b0);
      rel = 1'b1;
      cyc("rot_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
      rel = 1'b0;
      cyc("rot_next", oh((k + 1) % 4), 2'((k + 1) % 4), 1'b1, 1'b0);
    end

    // Skip an idle requester and wrap from 3 back to 0.
    req = 4'b0101;
    rel = 1'b1;
    cyc("skip_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    rel = 1'b0;
    cyc("skip_g2", 4'b0100, 2'd2, 1'b1, 1'b0);
    rel = 1'b1;
    cyc("wrap_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    rel = 1'b0;
    cyc("wrap_g0", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Owner 0 withdraws; requester 1 then holds until forcibly revoked.
    req = 4'b0110;
    cyc("wd0_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    cyc("to_g1", 4'b0010, 2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) cyc("to_hold", 4'b0010, 2'd1, 1'b1, 1'b0);
    cyc("to_pulse", 4'b0000, 2'd0, 1'b0, 1'b1);
    cyc("to_next_g2", 4'b0100, 2'd2, 1'b1, 1'b0);

    // Release on the very cycle the hold limit is reached: no timeout pulse.
    for (int i = 0; i < 15; i++) cyc("sim_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
    rel = 1'b1;
    cyc("sim_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    rel = 1'b0;
    req = 4'b0100;
    cyc("sim_g2", 4'b0100, 2'd2, 1'b1, 1'b0);

    // Mid-hold withdrawal, then rel while not busy is ignored.
    cyc("wd_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0000;
    cyc("wd_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    rel = 1'b1;
    cyc("rel_not_busy", 4'b0000, 2'd0, 1'b0, 1'b0);
    rel = 1'b0;
    cyc("idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Grant from IDLE at ptr=3, then asynchronous reset mid-grant.
    req = 4'b1000;
    cyc("g3", 4'b1000, 2'd3, 1'b1, 1'b0);
    cyc("g3_hold", 4'b1000, 2'd3, 1'b1, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    now_chk("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    cyc("rst_held", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b1111;
    rst = 1'b1;
    cyc("ptr_restart", 4'b0001, 2'd0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
